// File: rtl/aes_io_pkg.sv
// Shared constants and state encoding for the PS/2 to AES block path.
// Imported by the assembler interface and the assembler itself.
package aes_io_pkg;

  localparam int AES_BLOCK_W       = 128;
  localparam int NIBBLES_PER_BLOCK = 32;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } asm_state_t;

endpackage

// File: rtl/ps2_block_assembler_if.sv
// Nibble input strobes and block output handshake for the assembler.
// The master side drives the strobes; the slave side is the assembler.
interface ps2_block_assembler_if
  import aes_io_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_PER_BLOCK,
  parameter int CW      = 6
);

  logic [3:0]           nib;
  logic                 nib_valid;
  logic                 bksp;
  logic                 clr;
  logic                 sel_key;
  logic                 out_ready;
  logic                 out_valid;
  logic [4*NIBBLES-1:0] block_out;
  logic                 out_is_key;
  logic [CW-1:0]        nib_count;
  logic                 overflow;

  modport master (
    output nib, nib_valid, bksp, clr,
    output sel_key, out_ready,
    input  out_valid, block_out,
    input  out_is_key, nib_count, overflow
  );

  modport slave (
    input  nib, nib_valid, bksp, clr,
    input  sel_key, out_ready,
    output out_valid, block_out,
    output out_is_key, nib_count, overflow
  );

endinterface

// File: rtl/ps2_block_assembler.sv
// Shifts keyboard hex nibbles into a block, MSB first, and holds the
// finished block (tagged key/data) until the AES core takes it.
module ps2_block_assembler
  import aes_io_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_PER_BLOCK,
  parameter int CW      = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  ps2_block_assembler_if.slave  bus
);

  localparam int W = 4 * NIBBLES;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  asm_state_t    state, state_n;
  logic [W-1:0]  blk, blk_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          key, key_n;
  logic          ovf, ovf_n;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_COLLECT;
      blk   <= '0;
      cnt   <= '0;
      key   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      blk   <= blk_n;
      cnt   <= cnt_n;
      key   <= key_n;
      ovf   <= ovf_n;
    end
  end

  always_comb begin
    state_n = state;
    blk_n   = blk;
    cnt_n   = cnt;
    key_n   = key;
    ovf_n   = ovf;
    unique case (state)
      ST_COLLECT: begin
        if (bus.clr) begin
          blk_n = '0;
          cnt_n = '0;
          ovf_n = 1'b0;
        end else if (bus.bksp) begin
          if (cnt != '0) begin
            blk_n = {4'h0, blk[W-1:4]};
            cnt_n = cnt - 1'b1;
          end
        end else if (bus.nib_valid) begin
          blk_n = {blk[W-5:0], bus.nib};
          cnt_n = cnt + 1'b1;
          if (cnt == '0)
            key_n = bus.sel_key;
          if (cnt == LAST)
            state_n = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // clr wins over a same-cycle transfer
        if (bus.clr) begin
          state_n = ST_COLLECT;
          blk_n   = '0;
          cnt_n   = '0;
          ovf_n   = 1'b0;
        end else begin
          if (bus.out_ready) begin
            state_n = ST_COLLECT;
            blk_n   = '0;
            cnt_n   = '0;
          end
          if (bus.nib_valid)
            ovf_n = 1'b1;
        end
      end
      default: state_n = ST_COLLECT;
    endcase
  end

  assign bus.out_valid  = (state == ST_HOLD);
  assign bus.block_out  = blk;
  assign bus.out_is_key = key;
  assign bus.nib_count  = cnt;
  assign bus.overflow   = ovf;

endmodule

// File: tb/tb_ps2_block_assembler.sv
// Directed bench for ps2_block_assembler: key/data loads, backpressure,
// backspace, overflow, clear, simultaneous strobes and mid-block reset.
module tb_ps2_block_assembler;
  import aes_io_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   passed = 0;

  ps2_block_assembler_if #(.NIBBLES(32), .CW(6)) bus ();

  ps2_block_assembler #(.NIBBLES(32), .CW(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic strobe(input logic [3:0] n);
    bus.nib       = n;
    bus.nib_valid = 1'b1;
    tick();
    bus.nib_valid = 1'b0;
  endtask

  task automatic load(input logic [127:0] v);
    logic [127:0] t;
    t = v;
    for (int i = 0; i < 32; i++) begin
      strobe(t[127:124]);
      t = t << 4;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".valid"}, 128'(bus.out_valid), 128'd0);
    check({tag, ".block"}, bus.block_out, 128'd0);
    check({tag, ".count"}, 128'(bus.nib_count), 128'd0);
    check({tag, ".ovf"}, 128'(bus.overflow), 128'd0);
  endtask

  localparam logic [127:0] KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] DATA = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PAT  = 128'h0123456789abcdef0123456789abcdef;

  initial begin
    reset         = 1'b0;
    bus.nib       = 4'h0;
    bus.nib_valid = 1'b0;
    bus.bksp      = 1'b0;
    bus.clr       = 1'b0;
    bus.sel_key   = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check_zero("rst");
    check("rst.key", 128'(bus.out_is_key), 128'd0);
    reset = 1'b1;

    // key load
    bus.sel_key = 1'b1;
    strobe(4'h0);
    check("key.cnt1", 128'(bus.nib_count), 128'd1);
    check("key.val1", 128'(bus.out_valid), 128'd0);
    bus.sel_key = 1'b0;
    for (int i = 1; i < 32; i++) begin
      logic [127:0] t;
      t = KEY << (4 * i);
      strobe(t[127:124]);
    end
    check("key.valid", 128'(bus.out_valid), 128'd1);
    check("key.block", bus.block_out, KEY);
    check("key.is_key", 128'(bus.out_is_key), 128'd1);
    check("key.count", 128'(bus.nib_count), 128'd32);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check_zero("key.xfer");

    // data load with backpressure
    bus.sel_key = 1'b0;
    load(DATA);
    check("dat.is_key", 128'(bus.out_is_key), 128'd0);
    for (int i = 0; i < 10; i++) begin
      check("dat.hold_blk", bus.block_out, DATA);
      check("dat.hold_vld", 128'(bus.out_valid), 128'd1);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("dat.xfer_vld", 128'(bus.out_valid), 128'd0);
    check("dat.xfer_cnt", 128'(bus.nib_count), 128'd0);

    // back-to-back nibble then backspace
    strobe(4'ha);
    check("b2b.cnt", 128'(bus.nib_count), 128'd1);
    strobe(4'hb);
    strobe(4'hc);
    check("bk.abc", 128'(bus.block_out[11:0]), 128'habc);
    check("bk.cnt3", 128'(bus.nib_count), 128'd3);
    bus.bksp = 1'b1;
    tick();
    bus.bksp = 1'b0;
    check("bk.ab", bus.block_out, 128'hab);
    check("bk.cnt2", 128'(bus.nib_count), 128'd2);
    strobe(4'hd);
    check("bk.abd", bus.block_out, 128'habd);
    check("bk.cnt3b", 128'(bus.nib_count), 128'd3);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    check_zero("bk.clr");
    bus.bksp = 1'b1;
    tick();
    bus.bksp = 1'b0;
    check_zero("bk.zero");

    // overflow and clear
    load(PAT);
    check("ov.valid", 128'(bus.out_valid), 128'd1);
    strobe(4'h5);
    check("ov.flag", 128'(bus.overflow), 128'd1);
    check("ov.block", bus.block_out, PAT);
    check("ov.count", 128'(bus.nib_count), 128'd32);
    bus.bksp = 1'b1;
    tick();
    bus.bksp = 1'b0;
    check("ov.bksp", bus.block_out, PAT);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    check_zero("ov.clr");

    // nibble with backspace: nibble dropped
    strobe(4'h1);
    strobe(4'h2);
    strobe(4'h3);
    strobe(4'h4);
    check("sim.1234", bus.block_out, 128'h1234);
    bus.nib       = 4'h9;
    bus.nib_valid = 1'b1;
    bus.bksp      = 1'b1;
    tick();
    bus.nib_valid = 1'b0;
    bus.bksp      = 1'b0;
    check("sim.cnt", 128'(bus.nib_count), 128'd3);
    check("sim.blk", bus.block_out, 128'h123);
    check("sim.ovf", 128'(bus.overflow), 128'd0);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;

    // clr beats transfer in HOLD; overflow proves discard path
    load(DATA);
    strobe(4'h7);
    check("sim.ovf_set", 128'(bus.overflow), 128'd1);
    bus.clr       = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.clr       = 1'b0;
    bus.out_ready = 1'b0;
    check_zero("sim.clr_xfer");

    // reset mid-block
    bus.sel_key = 1'b1;
    for (int i = 0; i < 17; i++) strobe(4'(i));
    check("rm.cnt", 128'(bus.nib_count), 128'd17);
    check("rm.key", 128'(bus.out_is_key), 128'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_zero("rm");
    check("rm.key0", 128'(bus.out_is_key), 128'd0);

    // reset in HOLD with out_ready high
    load(KEY);
    check("rh.valid", 128'(bus.out_valid), 128'd1);
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    reset         = 1'b1;
    bus.out_ready = 1'b0;
    check_zero("rh");
    check("rh.key0", 128'(bus.out_is_key), 128'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
